fft_peak_finder: RTL and testbench

- Reader-side client of the FFT histogram BRAM: the FFT processor writes magnitude bins, and this block reads them back on the 104 MHz write-side clock.
- On each frame-complete pulse it scans a configured bin range and reports the strongest bin, its magnitude, and whether that magnitude clears a threshold.
- Feeds downstream note/fret detection logic and the seven-segment debug display.
- Uses one spare BRAM read port in the FFT clock domain; it never writes.

---
 rtl/fft_peak_finder.sv | 166 ++++++++++++++++
 tb/tb_fft_peak_finder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder.sv
// Scans a window of FFT magnitude bins through a read-only BRAM port after each
// frame-complete pulse and publishes the strongest bin, its magnitude and a threshold flag.
module fft_peak_finder #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 16,
   parameter int LO_BIN   = 2,
   parameter int HI_BIN   = 1023,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] threshold,
   output logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [DATA_W-1:0] peak_mag,
   output logic              peak_found,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] LO_ADDR = ADDR_W'(LO_BIN);
   localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(HI_BIN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   raddr_reg;
   logic                busy_reg;
   logic                done_reg;
   logic [ADDR_W-1:0]   peak_bin_reg;
   logic [DATA_W-1:0]   peak_mag_reg;
   logic                peak_found_reg;
   logic                overrun_reg;
   logic [DATA_W-1:0]   thr_reg;
   logic [DATA_W-1:0]   max_mag_reg;
   logic [ADDR_W-1:0]   max_bin_reg;

   // Tag pipeline: tracks which bin each returning rdata word belongs to.
   logic [READ_LAT-1:0]             vld_pipe_reg;
   logic [READ_LAT-1:0]             vld_pipe_next;
   logic [READ_LAT-1:0][ADDR_W-1:0] bin_pipe_reg;
   logic [READ_LAT-1:0][ADDR_W-1:0] bin_pipe_next;

   logic                push_vld;
   logic                head_vld;
   logic [ADDR_W-1:0]   head_bin;
   logic                head_hit;
   logic                last_cmp;
   logic [DATA_W-1:0]   max_mag_next;
   logic [ADDR_W-1:0]   max_bin_next;

   assign push_vld = (state_reg == ISSUE);
   assign head_vld = vld_pipe_reg[READ_LAT-1];
   assign head_bin = bin_pipe_reg[READ_LAT-1];

   generate
      for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_tag_pipe
         if (gi == 0) begin : g_entry
            assign vld_pipe_next[gi] = push_vld;
            assign bin_pipe_next[gi] = raddr_reg;
         end else begin : g_shift
            assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
            assign bin_pipe_next[gi] = bin_pipe_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_pipe_reg <= '0;
         bin_pipe_reg <= '0;
      end else begin
         vld_pipe_reg <= vld_pipe_next;
         bin_pipe_reg <= bin_pipe_next;
      end
   end

   // Strict greater-than keeps the lowest bin on ties.
   always_comb begin
      head_hit     = head_vld && (rdata > max_mag_reg);
      max_mag_next = head_hit ? rdata    : max_mag_reg;
      max_bin_next = head_hit ? head_bin : max_bin_reg;
      last_cmp     = head_vld && (head_bin == HI_ADDR);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         raddr_reg      <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         peak_bin_reg   <= '0;
         peak_mag_reg   <= '0;
         peak_found_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         thr_reg        <= '0;
         max_mag_reg    <= '0;
         max_bin_reg    <= '0;
      end else begin
         done_reg <= 1'b0;
         if (start && (state_reg != IDLE))
            overrun_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  thr_reg     <= threshold;
                  max_mag_reg <= '0;
                  max_bin_reg <= LO_ADDR;
                  raddr_reg   <= LO_ADDR;
                  busy_reg    <= 1'b1;
                  state_reg   <= ISSUE;
               end
            end

            ISSUE: begin
               max_mag_reg <= max_mag_next;
               max_bin_reg <= max_bin_next;
               if (raddr_reg == HI_ADDR)
                  state_reg <= DRAIN;
               else
                  raddr_reg <= raddr_reg + 1'b1;
            end

            DRAIN: begin
               max_mag_reg <= max_mag_next;
               max_bin_reg <= max_bin_next;
               // Publish on the final compare so done is high during the DONE cycle.
               if (last_cmp) begin
                  peak_bin_reg   <= max_bin_next;
                  peak_mag_reg   <= max_mag_next;
                  peak_found_reg <= (max_mag_next >= thr_reg);
                  done_reg       <= 1'b1;
                  busy_reg       <= 1'b0;
                  state_reg      <= DONE;
               end
            end

            DONE: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign raddr      = raddr_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign peak_bin   = peak_bin_reg;
   assign peak_mag   = peak_mag_reg;
   assign peak_found = peak_found_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed scoreboard bench for fft_peak_finder: BRAM model with READ_LAT registered
// read stages, expected peaks pushed at start and popped on each done pulse.
module tb_fft_peak_finder;

   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 16;
   localparam int LO_BIN   = 2;
   localparam int HI_BIN   = 1023;
   localparam int READ_LAT = 2;
   localparam int N_BINS   = HI_BIN - LO_BIN + 1;
   localparam int LAT      = N_BINS + READ_LAT + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] bin;
      logic [DATA_W-1:0] mag;
      logic              found;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [DATA_W-1:0] threshold;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] peak_bin;
   logic [DATA_W-1:0] peak_mag;
   logic              peak_found;
   logic              overrun;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   exp_t exp_q[$];

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_pipe [0:READ_LAT-1];

   fft_peak_finder #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .LO_BIN   (LO_BIN),
      .HI_BIN   (HI_BIN),
      .READ_LAT (READ_LAT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .threshold  (threshold),
      .raddr      (raddr),
      .rdata      (rdata),
      .busy       (busy),
      .done       (done),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
      .peak_found (peak_found),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_pipe[0] <= mem[raddr];
      for (int i = 1; i < READ_LAT; i++)
         rd_pipe[i] <= rd_pipe[i-1];
   end
   assign rdata = rd_pipe[READ_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, " raddr"},      32'(raddr),      32'd0);
      check({name, " busy"},       32'(busy),       32'd0);
      check({name, " done"},       32'(done),       32'd0);
      check({name, " peak_bin"},   32'(peak_bin),   32'd0);
      check({name, " peak_mag"},   32'(peak_mag),   32'd0);
      check({name, " peak_found"}, 32'(peak_found), 32'd0);
      check({name, " overrun"},    32'(overrun),    32'd0);
   endtask

   task automatic clear_mem();
      for (int b = 0; b < (1 << ADDR_W); b++)
         mem[b] = '0;
   endtask

   task automatic ramp_mem();
      for (int b = 0; b < (1 << ADDR_W); b++)
         mem[b] = DATA_W'(b & 8'hFF);
      mem[300] = 16'h4000;
   endtask

   // Straight sequential reference scan over the bin window.
   function automatic exp_t model(input logic [DATA_W-1:0] thr);
      exp_t e;
      e.bin = ADDR_W'(LO_BIN);
      e.mag = '0;
      for (int b = LO_BIN; b <= HI_BIN; b++) begin
         if (mem[b] > e.mag) begin
            e.mag = mem[b];
            e.bin = ADDR_W'(b);
         end
      end
      e.found = (e.mag >= thr);
      return e;
   endfunction

   task automatic scan(input string name, input logic [DATA_W-1:0] thr,
                       input int thr_at, input logic [DATA_W-1:0] thr_new,
                       input int restart_at, input bit restart_in_done,
                       input int rst_at);
      exp_t e;
      exp_t got;
      int   busy_cnt;
      int   done_cnt;
      int   first_busy;
      int   amin;
      int   amax;
      bit   exp_ovr;
      e = model(thr);
      exp_ovr = (restart_at >= 0) || restart_in_done;
      threshold = thr;
      start = 1'b1;
      exp_q.push_back(e);
      tick();
      busy_cnt = 0;
      done_cnt = 0;
      first_busy = -1;
      amin = 1 << ADDR_W;
      amax = -1;
      for (int c = 1; c <= LAT + 8; c++) begin
         start = 1'b0;
         if ((rst_at < 0) || (c <= rst_at)) begin
            if (int'(raddr) < amin) amin = int'(raddr);
            if (int'(raddr) > amax) amax = int'(raddr);
         end
         if (busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = c;
         end
         if (done) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
               got = exp_q.pop_front();
               check({name, " latency"},    32'(c),          32'(LAT));
               check({name, " peak_bin"},   32'(peak_bin),   32'(got.bin));
               check({name, " peak_mag"},   32'(peak_mag),   32'(got.mag));
               check({name, " peak_found"}, 32'(peak_found), 32'(got.found));
               check({name, " busy@done"},  32'(busy),       32'd0);
               $display("%s: done at start+%0d bin=%0d mag=0x%04h found=%0b overrun=%0b",
                        name, c, peak_bin, peak_mag, peak_found, overrun);
            end
            if (restart_in_done) start = 1'b1;
         end
         if (c == restart_at) start = 1'b1;
         if (c == thr_at) threshold = thr_new;
         if ((rst_at >= 0) && (c == rst_at + 1)) begin
            check_zero({name, " post-reset"});
            reset_n = 1'b1;
            $display("%s: reset applied at start+%0d, outputs cleared", name, rst_at);
         end
         if (c == rst_at) begin
            reset_n = 1'b0;
            exp_q.delete();
         end
         tick();
      end
      start = 1'b0;
      exp_q.delete();
      check({name, " done count"}, 32'(done_cnt), (rst_at < 0) ? 32'd1 : 32'd0);
      check({name, " raddr min"},  32'(amin),     32'(LO_BIN));
      if (rst_at < 0) begin
         check({name, " busy cycles"}, 32'(busy_cnt),   32'(N_BINS + READ_LAT));
         check({name, " busy first"},  32'(first_busy), 32'd1);
         check({name, " raddr max"},   32'(amax),       32'(HI_BIN));
         check({name, " hold bin"},    32'(peak_bin),   32'(e.bin));
         check({name, " hold mag"},    32'(peak_mag),   32'(e.mag));
         check({name, " overrun"},     32'(overrun),    32'(exp_ovr));
      end else begin
         check({name, " raddr in range"}, 32'(amax <= HI_BIN), 32'd1);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      threshold = '0;
      clear_mem();
      repeat (3) tick();
      check_zero("reset");
      reset_n = 1'b1;

      ramp_mem();
      while (cyc < 10) tick();
      scan("t1_basic", 16'h1000, -1, 16'h0000, -1, 1'b0, -1);

      clear_mem();
      mem[100] = 16'h7FFF;
      mem[500] = 16'h7FFF;
      repeat (3) tick();
      scan("t2_tie", 16'h7FFF, -1, 16'h0000, -1, 1'b0, -1);

      clear_mem();
      mem[40] = 16'h0800;
      scan("t3_thresh", 16'h0900, 300, 16'h0100, -1, 1'b0, -1);

      clear_mem();
      mem[0]    = 16'hFFFF;
      mem[1]    = 16'hFFFF;
      mem[1024] = 16'hFFFF;
      mem[2]    = 16'h0010;
      scan("t4_range", 16'h0010, -1, 16'h0000, -1, 1'b0, -1);

      clear_mem();
      scan("zero_thr0", 16'h0000, -1, 16'h0000, -1, 1'b0, -1);
      scan("zero_thr1", 16'h0001, -1, 16'h0000, -1, 1'b0, -1);

      ramp_mem();
      scan("t5_overrun", 16'h1000, -1, 16'h0000, 500, 1'b1, -1);
      for (int i = 0; i < 5; i++) begin
         check("t5 overrun sticky", 32'(overrun), 32'd1);
         tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_zero("t5 reset");
      $display("t5_overrun: overrun cleared by reset");
      tick();

      scan("t6_reset", 16'h1000, -1, 16'h0000, -1, 1'b0, 600);
      scan("t6_rescan", 16'h1000, -1, 16'h0000, -1, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
